fetch_redirect_unit: RTL and testbench
======================================

Name: fetch_redirect_unit

Overview:
- IF-stage PC sequencer and IF/ID pipeline register. It consumes the branch decision (PCSrc) and jump request resolved in ID.
- Redirects the PC, squashes the wrong-path instruction in IF/ID, and obeys the hazard unit's stall.
- Detects the halt word and drains the pipeline before signalling completion.
- Sits between instruction memory and the ID stage.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops fetch.
- DRAIN_CYCLES, 4, cycles spent in DRAIN before Done asserts; legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- PCSrc  in  1  branch taken, from the branch unit (ID stage).
- BranchTarget  in  32  branch target address computed in ID.
- Jump  in  1  jump decoded in ID.
- JumpTarget  in  32  jump target address computed in ID.
- StallF  in  1  hazard unit request to hold PC and IF/ID.
- InstrF  in  32  instruction memory read data for PCF (combinational).
- PCF  out  32  instruction fetch address.
- InstrD  out  32  IF/ID instruction.
- PCPlus4D  out  32  IF/ID PC+4.
- ValidD  out  1  IF/ID holds a real instruction.
- FlushD  out  1  combinational; high in any cycle where a redirect is accepted.
- Done  out  1  pipeline drained after halt.

Behaviour:
- Reset (synchronous, active-high), sampled on clk:
  - PCF=RESET_PC, InstrD=0, PCPlus4D=0, ValidD=0, Done=0, state=RUN, drain counter=0.
  - Reset overrides every other input and returns to RUN from any state.
- Redirect condition: redirect = (PCSrc | Jump) & ~StallF & state==RUN. PCSrc wins over Jump if both are high. Next PC is BranchTarget or JumpTarget respectively.
- FlushD = redirect.
- RUN, StallF=1: PCF, InstrD, PCPlus4D and ValidD hold. PCSrc and Jump are ignored that cycle; the branch unit re-presents them after the stall.
- RUN, redirect: PCF <= target. IF/ID loads a bubble (InstrD=0 NOP, PCPlus4D=0, ValidD=0). The instruction currently in IF is discarded, even if it is HALT_WORD.
- RUN, no stall, no redirect, InstrF != HALT_WORD: PCF <= PCF+4 (32-bit wrap, 32'hFFFF_FFFC -> 0). InstrD <= InstrF, PCPlus4D <= PCF+4, ValidD <= 1.
- RUN, no stall, no redirect, InstrF == HALT_WORD: PCF holds, IF/ID loads a bubble, state -> DRAIN, counter <= 0.
- DRAIN:
  - PCF holds, IF/ID loads a bubble every cycle, and PCSrc, Jump and StallF are ignored.
  - The counter increments each cycle. When counter == DRAIN_CYCLES-1, state -> HALTED.
- HALTED: Done=1 (registered; first high the cycle after the last DRAIN cycle). All outputs hold until reset.
- Latency:
  - PCF updates one cycle after the accepted condition.
  - IF/ID is one-cycle registered.
  - A taken branch costs exactly one bubble.
- Simultaneous events:
  - StallF with HALT_WORD in IF: hold, no halt entry.
  - Redirect with HALT_WORD in IF: redirect taken, halt not entered.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined:
  - Adds outputs RedirectCount[31:0] (increments on every accepted redirect) and StallCount[31:0] (increments on every RUN cycle with StallF=1).
  - Both reset to 0 and wrap modulo 2^32.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then 3 free cycles with InstrF=32'h2001_0005: PCF goes 0 -> 4 -> 8 -> C. InstrD=32'h2001_0005, PCPlus4D=8 after the 2nd edge, ValidD=1.
- At PCF=8, pulse PCSrc=1 with BranchTarget=32'h40: FlushD=1 that cycle. Next cycle PCF=40, InstrD=0, ValidD=0. The following cycle PCF=44 with a valid instruction.
- StallF=1 for 2 cycles together with PCSrc=1 at PCF=10: PCF and IF/ID hold, FlushD=0. Then StallF=0 with PCSrc still 1 and BranchTarget=80: PCF=80 next cycle.
- PCSrc=1 and Jump=1 together, BranchTarget=100, JumpTarget=200: PCF=100 next cycle.
- InstrF=HALT_WORD at PCF=20, DRAIN_CYCLES=4: PCF stays 20, 4 bubble cycles follow, and Done=1 on the 5th edge. Then apply reset: PCF=0, Done=0, state RUN.
- With FETCH_STATS_EN: 2 redirects and 3 stall cycles -> RedirectCount=2, StallCount=3. A redirect while HALT_WORD is in IF leaves Done=0 and redirects normally.

Source files
------------

// File: rtl/fetch_redirect_unit.sv
// IF-stage PC sequencer and IF/ID register with branch/jump redirect and halt drain.
// Optional FETCH_STATS_EN adds redirect and stall counters.
module fetch_redirect_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrc,
    input  logic [31:0] BranchTarget,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        StallF,
    input  logic [31:0] InstrF,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic        FlushD,
    output logic        Done
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] RedirectCount,
    output logic [31:0] StallCount
`endif
);

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        HALTED
    } state_t;

    localparam logic [3:0] LAST = 4'(DRAIN_CYCLES - 1);

    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [31:0] pc_n, instr_n, pc4_n;
    logic        valid_n;
    logic        redirect;
    logic [31:0] pcplus4;

    assign pcplus4  = PCF + 32'd4;
    assign redirect = (PCSrc | Jump) & ~StallF & (state == RUN);
    assign FlushD   = redirect;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pc_n    = PCF;
        instr_n = InstrD;
        pc4_n   = PCPlus4D;
        valid_n = ValidD;
        unique case (state)
            RUN: begin
                if (!StallF) begin
                    // default to a bubble; only a normal fetch fills IF/ID
                    instr_n = 32'd0;
                    pc4_n   = 32'd0;
                    valid_n = 1'b0;
                    if (redirect) begin
                        pc_n = PCSrc ? BranchTarget : JumpTarget;
                    end else if (InstrF == HALT_WORD) begin
                        state_n = DRAIN;
                        cnt_n   = 4'd0;
                    end else begin
                        pc_n    = pcplus4;
                        instr_n = InstrF;
                        pc4_n   = pcplus4;
                        valid_n = 1'b1;
                    end
                end
            end
            DRAIN: begin
                instr_n = 32'd0;
                pc4_n   = 32'd0;
                valid_n = 1'b0;
                cnt_n   = cnt + 4'd1;
                if (cnt == LAST) begin
                    state_n = HALTED;
                end
            end
            HALTED: begin
                state_n = HALTED;
            end
            default: begin
                state_n = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= RUN;
            cnt      <= 4'd0;
            PCF      <= RESET_PC;
            InstrD   <= 32'd0;
            PCPlus4D <= 32'd0;
            ValidD   <= 1'b0;
            Done     <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            PCF      <= pc_n;
            InstrD   <= instr_n;
            PCPlus4D <= pc4_n;
            ValidD   <= valid_n;
            Done     <= (state_n == HALTED);
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            RedirectCount <= 32'd0;
            StallCount    <= 32'd0;
        end else begin
            if (redirect) begin
                RedirectCount <= RedirectCount + 32'd1;
            end
            if (StallF && state == RUN) begin
                StallCount <= StallCount + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed table-driven bench for fetch_redirect_unit.
// Covers redirect, stall, wrap, halt drain and reset; checks counters under FETCH_STATS_EN.
module tb_fetch_redirect_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrc;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        StallF;
    logic [31:0] InstrF;
    logic [31:0] PCF, InstrD, PCPlus4D;
    logic        ValidD, FlushD, Done;
`ifdef FETCH_STATS_EN
    logic [31:0] RedirectCount, StallCount;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_redirect_unit dut (
        .clk          (clk),
        .reset        (reset),
        .PCSrc        (PCSrc),
        .BranchTarget (BranchTarget),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .StallF       (StallF),
        .InstrF       (InstrF),
        .PCF          (PCF),
        .InstrD       (InstrD),
        .PCPlus4D     (PCPlus4D),
        .ValidD       (ValidD),
        .FlushD       (FlushD),
        .Done         (Done)
`ifdef FETCH_STATS_EN
        ,
        .RedirectCount(RedirectCount),
        .StallCount   (StallCount)
`endif
    );

    typedef struct {
        logic        pcsrc;
        logic [31:0] bt;
        logic        jump;
        logic [31:0] jt;
        logic        stall;
        logic [31:0] instr;
        logic        fl;
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] p4;
        logic        v;
        logic        d;
    } vec_t;

    localparam logic [31:0] I  = 32'h2001_0005;
    localparam logic [31:0] A  = 32'h00A0_0093;
    localparam logic [31:0] B  = 32'h0041_0113;
    localparam logic [31:0] X  = 32'h1111_1111;
    localparam logic [31:0] H  = 32'hFFFF_FFFF;

    vec_t tv[24];

    function automatic vec_t mk(
        logic pcsrc, logic [31:0] bt, logic jump, logic [31:0] jt,
        logic stall, logic [31:0] instr, logic fl, logic [31:0] pc,
        logic [31:0] ins, logic [31:0] p4, logic v, logic d);
        vec_t r;
        r.pcsrc = pcsrc; r.bt = bt; r.jump = jump; r.jt = jt;
        r.stall = stall; r.instr = instr; r.fl = fl; r.pc = pc;
        r.ins = ins; r.p4 = p4; r.v = v; r.d = d;
        return r;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%h exp=%h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        PCSrc        = t.pcsrc;
        BranchTarget = t.bt;
        Jump         = t.jump;
        JumpTarget   = t.jt;
        StallF       = t.stall;
        InstrF       = t.instr;
    endtask

    initial begin
        tv[0]  = mk(0, 0,   0, 0,   0, I, 0, 32'h4,   I, 32'h4,  1, 0);
        tv[1]  = mk(0, 0,   0, 0,   0, I, 0, 32'h8,   I, 32'h8,  1, 0);
        tv[2]  = mk(1, 32'h40, 0, 0, 0, I, 1, 32'h40, 0, 0,      0, 0);
        tv[3]  = mk(0, 0,   0, 0,   0, I, 0, 32'h44,  I, 32'h44, 1, 0);
        tv[4]  = mk(0, 0,   1, 32'hC, 0, I, 1, 32'hC, 0, 0,      0, 0);
        tv[5]  = mk(0, 0,   0, 0,   0, A, 0, 32'h10,  A, 32'h10, 1, 0);
        tv[6]  = mk(1, 32'h80, 0, 0, 1, X, 0, 32'h10, A, 32'h10, 1, 0);
        tv[7]  = mk(1, 32'h80, 0, 0, 1, X, 0, 32'h10, A, 32'h10, 1, 0);
        tv[8]  = mk(1, 32'h80, 0, 0, 0, X, 1, 32'h80, 0, 0,      0, 0);
        tv[9]  = mk(1, 32'h100, 1, 32'h200, 0, I, 1, 32'h100, 0, 0, 0, 0);
        tv[10] = mk(0, 0, 1, 32'hFFFF_FFFC, 0, I, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        tv[11] = mk(0, 0,   0, 0,   0, I, 0, 32'h0,   I, 32'h0,  1, 0);
        tv[12] = mk(0, 0,   1, 32'h1C, 0, I, 1, 32'h1C, 0, 0,    0, 0);
        tv[13] = mk(0, 0,   0, 0,   0, B, 0, 32'h20,  B, 32'h20, 1, 0);
        tv[14] = mk(0, 0,   0, 0,   1, H, 0, 32'h20,  B, 32'h20, 1, 0);
        tv[15] = mk(1, 32'h18, 0, 0, 0, H, 1, 32'h18, 0, 0,      0, 0);
        tv[16] = mk(0, 0,   0, 0,   0, I, 0, 32'h1C,  I, 32'h1C, 1, 0);
        tv[17] = mk(0, 0,   0, 0,   0, I, 0, 32'h20,  I, 32'h20, 1, 0);
        tv[18] = mk(0, 0,   0, 0,   0, H, 0, 32'h20,  0, 0,      0, 0);
        tv[19] = mk(1, 32'h300, 0, 0, 1, I, 0, 32'h20, 0, 0,     0, 0);
        tv[20] = mk(1, 32'h300, 0, 0, 1, I, 0, 32'h20, 0, 0,     0, 0);
        tv[21] = mk(0, 0,   1, 32'h400, 0, I, 0, 32'h20, 0, 0,   0, 0);
        tv[22] = mk(0, 0,   0, 0,   0, I, 0, 32'h20,  0, 0,      0, 1);
        tv[23] = mk(1, 32'h500, 1, 32'h600, 0, I, 0, 32'h20, 0, 0, 0, 1);

        reset = 1'b1;
        drive(mk(0, 0, 0, 0, 0, I, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pcf", 0, PCF, 32'h0);
        chk("rst_instrd", 0, InstrD, 32'h0);
        chk("rst_pc4d", 0, PCPlus4D, 32'h0);
        chk("rst_validd", 0, 32'(ValidD), 32'd0);
        chk("rst_done", 0, 32'(Done), 32'd0);
`ifdef FETCH_STATS_EN
        chk("rst_redir_cnt", 0, RedirectCount, 32'd0);
        chk("rst_stall_cnt", 0, StallCount, 32'd0);
`endif
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 24; i++) begin
            drive(tv[i]);
            #1;
            chk("flushd", i, 32'(FlushD), 32'(tv[i].fl));
            @(posedge clk);
            #1;
            chk("pcf", i, PCF, tv[i].pc);
            chk("instrd", i, InstrD, tv[i].ins);
            chk("pc4d", i, PCPlus4D, tv[i].p4);
            chk("validd", i, 32'(ValidD), 32'(tv[i].v));
            chk("done", i, 32'(Done), 32'(tv[i].d));
            @(negedge clk);
        end

`ifdef FETCH_STATS_EN
        chk("redir_cnt", 0, RedirectCount, 32'd7);
        chk("stall_cnt", 0, StallCount, 32'd3);
`endif

        // reset out of HALTED, then confirm fetch resumes
        reset = 1'b1;
        drive(mk(1, 32'h700, 1, 32'h800, 0, I, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("rst2_pcf", 0, PCF, 32'h0);
        chk("rst2_done", 0, 32'(Done), 32'd0);
        chk("rst2_validd", 0, 32'(ValidD), 32'd0);
        chk("rst2_flushd", 0, 32'(FlushD), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        drive(mk(0, 0, 0, 0, 0, I, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        chk("run_pcf", 0, PCF, 32'h4);
        chk("run_instrd", 0, InstrD, I);
        chk("run_validd", 0, 32'(ValidD), 32'd1);
`ifdef FETCH_STATS_EN
        chk("rst2_redir_cnt", 0, RedirectCount, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
